m6502_intc: RTL

M6502_INTC -- requirements
Module: m6502_intc

---
 rtl/m6502_intc_pkg.sv | 18 +
 rtl/m6502_intc_sync.sv | 32 +++
 rtl/m6502_intc.sv | 104 ++++++++++
 3 files changed

// File: rtl/m6502_intc_pkg.sv
// Shared constants for the 6502 interrupt controller: source count,
// register offsets, reset values and VEC layout.
package m6502_intc_pkg;

  localparam int NSRC = 8;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_MODE = 2'd2;
  localparam logic [1:0] OFF_VEC  = 2'd3;

  localparam logic [NSRC-1:0] RST_PEND = '0;
  localparam logic [NSRC-1:0] RST_MASK = '0;
  localparam logic [NSRC-1:0] RST_MODE = '0;

  localparam int VEC_ACT_BIT = 7;

endpackage

// File: rtl/m6502_intc_sync.sv
// Two-flop synchronizer for the peripheral requests plus rising-edge detect
// on the synchronized value.
module m6502_intc_sync
  import m6502_intc_pkg::*;
(
  input  logic            clk,
  input  logic            res_n,
  input  logic [NSRC-1:0] i_src,
  output logic [NSRC-1:0] o_s2,
  output logic [NSRC-1:0] o_rise
);

  logic [NSRC-1:0] r_s1;
  logic [NSRC-1:0] r_s2;
  logic [NSRC-1:0] r_hist;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_hist <= '0;
    end else begin
      r_s1   <= i_src;
      r_s2   <= r_s1;
      r_hist <= r_s2;
    end
  end

  assign o_s2   = r_s2;
  assign o_rise = r_s2 & ~r_hist;

endmodule

// File: rtl/m6502_intc.sv
// Memory-mapped 8-source interrupt controller for a 6502 bus: pending,
// mask and mode registers, priority vector and registered irq_n.
module m6502_intc
  import m6502_intc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFE00
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic [15:0]     addr,
  input  logic [7:0]      datai,
  input  logic            we_n,
  input  logic [NSRC-1:0] src,
  output logic [7:0]      datao,
  output logic            sel,
  output logic            irq_n
);

  logic [NSRC-1:0] w_s2;
  logic [NSRC-1:0] w_rise;
  logic [15:0]     w_rel;
  logic [1:0]      w_off;
  logic            w_hit;
  logic            w_wr;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_modechg;
  logic [NSRC-1:0] w_pend_edge;
  logic [NSRC-1:0] w_pend_rule;
  logic [NSRC-1:0] w_pend_nxt;
  logic [NSRC-1:0] w_act;
  logic [2:0]      w_idx;
  logic [7:0]      w_vec;

  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_mode;
  logic            r_irq_n;

  m6502_intc_sync u_sync (
    .clk    (clk),
    .res_n  (res_n),
    .i_src  (src),
    .o_s2   (w_s2),
    .o_rise (w_rise)
  );

  assign w_rel = addr - BASE_ADDR;
  assign w_off = w_rel[1:0];
  assign w_hit = (w_rel[15:2] == 14'd0);
  assign w_wr  = w_hit && !we_n;
  assign sel   = w_hit && we_n;

  assign w_clr     = (w_wr && w_off == OFF_PEND) ? datai : '0;
  assign w_modechg = (w_wr && w_off == OFF_MODE) ? (datai ^ r_mode) : '0;

  // Rising edge is OR-ed in after the clear so a same-cycle set wins.
  assign w_pend_edge = (r_pend & ~w_clr) | w_rise;
  assign w_pend_rule = (r_mode & w_pend_edge) | (~r_mode & w_s2);
  assign w_pend_nxt  = (w_modechg & r_pend) | (~w_modechg & w_pend_rule);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_pend  <= RST_PEND;
      r_mask  <= RST_MASK;
      r_mode  <= RST_MODE;
      r_irq_n <= 1'b1;
    end else begin
      r_pend  <= w_pend_nxt;
      r_irq_n <= ~|w_act;
      if (w_wr && w_off == OFF_MASK) r_mask <= datai;
      if (w_wr && w_off == OFF_MODE) r_mode <= datai;
    end
  end

  assign w_act = r_pend & r_mask;
  assign irq_n = r_irq_n;

  // Lowest-numbered active source has priority.
  always_comb begin
    w_idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_act[i]) w_idx = 3'(i);
    end
  end

  always_comb begin
    w_vec              = 8'h00;
    w_vec[VEC_ACT_BIT] = |w_act;
    w_vec[2:0]         = w_idx;
  end

  always_comb begin
    datao = 8'h00;
    if (sel) begin
      case (w_off)
        OFF_PEND: datao = r_pend;
        OFF_MASK: datao = r_mask;
        OFF_MODE: datao = r_mode;
        default:  datao = w_vec;
      endcase
    end
  end

endmodule
